// File: rtl/div_remainder_unit.sv
// div_remainder_unit
//   Multicycle restoring divider sitting between the Divisor register and the
//   ALU/writeback result path. A request is accepted from IDLE on Start. The
//   unit then retires one quotient bit per clock in a 2*WIDTH-bit remainder
//   register and presents the result with a one-cycle Done pulse.
//
//   Optional feature: define DIV_SIGNED_EN for two's-complement operands.
//   Magnitudes are divided, and the signs are restored on entry to DONE.
//   Without the macro the unit is unsigned only.
//
// Handshake: Start is a request and Busy is the inverse of ready. A request
//   is taken only on a clock edge where Start==1 and Busy==0. Start while
//   Busy==1 is ignored. Done is a one-cycle pulse marking results valid.
//   Quotient_out/Remainder_out are held until the next result is produced.
//
// Ports
//   clk            rising-edge clock
//   Reset          asynchronous active-low reset
//   Start          divide request, sampled only in IDLE
//   Dividend_in    dividend, latched on the accepting edge
//   Divisor_in     divisor, latched on the accepting edge
//   Busy           high in CALC and DONE
//   Done           one-cycle result-valid pulse
//   DivZero        divisor was zero for the current result
//   Quotient_out   quotient (all ones on divide by zero)
//   Remainder_out  remainder (dividend on divide by zero)
//   state_dbg      current FSM state (0 IDLE, 1 CALC, 2 DONE)
module div_remainder_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend_in,
    input  logic [WIDTH-1:0] Divisor_in,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Quotient_out,
    output logic [WIDTH-1:0] Remainder_out,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   rem_q;
    logic [2*WIDTH-1:0]   shifted;
    logic [2*WIDTH-1:0]   rem_step;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     div_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     res_rem_q;
    logic                 dz_q;
    logic                 done_q;
    logic                 divisor_zero;
    logic [WIDTH-1:0]     dvd_mag;
    logic [WIDTH-1:0]     dvs_mag;
    logic [WIDTH-1:0]     final_quo;
    logic [WIDTH-1:0]     final_rem;

    assign divisor_zero = (Divisor_in == '0);

    // One restoring step: shift left, trial-subtract the divisor from the
    // upper half, keep the difference and set the quotient bit if no borrow.
    always_comb begin
        shifted  = {rem_q[2*WIDTH-2:0], 1'b0};
        trial    = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, div_q};
        rem_step = shifted;
        if (!trial[WIDTH]) begin
            rem_step = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
        end
    end

`ifdef DIV_SIGNED_EN
    logic quo_neg_q;
    logic rem_neg_q;

    // The magnitude of the most negative value is correct as an unsigned number.
    always_comb begin
        dvd_mag   = Dividend_in[WIDTH-1] ? (~Dividend_in + 1'b1) : Dividend_in;
        dvs_mag   = Divisor_in[WIDTH-1]  ? (~Divisor_in  + 1'b1) : Divisor_in;
        final_quo = quo_neg_q ? (~rem_step[WIDTH-1:0] + 1'b1) : rem_step[WIDTH-1:0];
        final_rem = rem_neg_q ? (~rem_step[2*WIDTH-1:WIDTH] + 1'b1)
                              : rem_step[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (state == S_IDLE && Start) begin
            quo_neg_q <= Dividend_in[WIDTH-1] ^ Divisor_in[WIDTH-1];
            rem_neg_q <= Dividend_in[WIDTH-1];
        end
    end
`else
    always_comb begin
        dvd_mag   = Dividend_in;
        dvs_mag   = Divisor_in;
        final_quo = rem_step[WIDTH-1:0];
        final_rem = rem_step[2*WIDTH-1:WIDTH];
    end
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nxt = divisor_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == LAST_CNT) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            rem_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            quo_q     <= '0;
            res_rem_q <= '0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        rem_q <= {{WIDTH{1'b0}}, dvd_mag};
                        div_q <= dvs_mag;
                        cnt_q <= '0;
                        if (divisor_zero) begin
                            // The iteration is skipped, so the results go straight to DONE.
                            quo_q     <= '1;
                            res_rem_q <= Dividend_in;
                            dz_q      <= 1'b1;
                        end else begin
                            dz_q <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= rem_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        quo_q     <= final_quo;
                        res_rem_q <= final_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy          = (state != S_IDLE);
    assign Done          = done_q;
    assign DivZero       = dz_q;
    assign Quotient_out  = quo_q;
    assign Remainder_out = res_rem_q;
    assign state_dbg     = state;

endmodule
